// File: rtl/shared_adder_sequencer.sv
// Two requesters share a single 4-bit adder that walks WIDTH-bit operands
// one nibble per cycle, LSB first, with round-robin arbitration.
module shared_adder_sequencer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_cin,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic             res_id
);

    localparam int unsigned SLICES = WIDTH / 4;
    localparam int unsigned IW     = (SLICES > 1) ? $clog2(SLICES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic [IW-1:0]    idx_q;
    logic             last_grant;
    logic             last_slice;
    logic [3:0]       slice_a;
    logic [3:0]       slice_b;
    logic [3:0]       slice_sum;
    logic             slice_cout;

    assign res_sum    = sum_q;
    assign last_slice = (idx_q == IW'(SLICES - 1));

    // Select the current nibble of each captured operand
    always_comb begin
        slice_a = 4'h0;
        slice_b = 4'h0;
        for (int i = 0; i < int'(SLICES); i++) begin
            if (idx_q == IW'(i)) begin
                slice_a = a_q[i*4 +: 4];
                slice_b = b_q[i*4 +: 4];
            end
        end
    end

    four_bit_adder u_add (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state and round-robin readiness
    always_comb begin
        state_d    = state_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state_q)
            IDLE: begin
                req0_ready = !rst && req0_valid && (!req1_valid || last_grant != 1'b0);
                req1_ready = !rst && req1_valid && (!req0_valid || last_grant != 1'b1);
                if (req0_ready || req1_ready) state_d = RUN;
            end
            RUN:  if (last_slice) state_d = DONE;
            DONE: if (res_ready)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, slice accumulation and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q        <= '0;
            b_q        <= '0;
            sum_q      <= '0;
            carry_q    <= 1'b0;
            idx_q      <= '0;
            last_grant <= 1'b1;
            res_valid  <= 1'b0;
            res_cout   <= 1'b0;
            res_id     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req0_ready) begin
                        a_q        <= req0_a;
                        b_q        <= req0_b;
                        carry_q    <= req0_cin;
                        idx_q      <= '0;
                        res_id     <= 1'b0;
                        last_grant <= 1'b0;
                    end else if (req1_ready) begin
                        a_q        <= req1_a;
                        b_q        <= req1_b;
                        carry_q    <= req1_cin;
                        idx_q      <= '0;
                        res_id     <= 1'b1;
                        last_grant <= 1'b1;
                    end
                end
                RUN: begin
                    for (int i = 0; i < int'(SLICES); i++) begin
                        if (idx_q == IW'(i)) sum_q[i*4 +: 4] <= slice_sum;
                    end
                    carry_q <= slice_cout;
                    if (last_slice) begin
                        res_cout  <= slice_cout;
                        res_valid <= 1'b1;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                DONE: begin
                    if (res_ready) res_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// Plain 4-bit ripple adder shared by the sequencer
module four_bit_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    assign {cout, sum} = 5'(a) + 5'(b) + 5'(cin);
endmodule

// File: tb/tb_shared_adder_sequencer.sv
// Directed bench for shared_adder_sequencer (16-bit and 4-bit builds).
module tb_shared_adder_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        r0v, r1v, r0c, r1c, rr;
    logic [15:0] r0a, r0b, r1a, r1b;
    logic        rdy0, rdy1, res_valid, res_cout, res_id;
    logic [15:0] res_sum;

    logic        v4, c4, rr4, rdy4, unused_rdy4b, rv4, co4, id4;
    logic [3:0]  a4, b4, s4;

    int total  = 0;
    int passed = 0;
    int n;
    bit seen;

    always #5 clk = ~clk;

    shared_adder_sequencer #(.WIDTH(16)) u0 (
        .clk(clk), .rst(rst),
        .req0_valid(r0v), .req0_ready(rdy0), .req0_a(r0a), .req0_b(r0b), .req0_cin(r0c),
        .req1_valid(r1v), .req1_ready(rdy1), .req1_a(r1a), .req1_b(r1b), .req1_cin(r1c),
        .res_valid(res_valid), .res_ready(rr), .res_sum(res_sum),
        .res_cout(res_cout), .res_id(res_id)
    );

    shared_adder_sequencer #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst),
        .req0_valid(v4), .req0_ready(rdy4), .req0_a(a4), .req0_b(b4), .req0_cin(c4),
        .req1_valid(1'b0), .req1_ready(unused_rdy4b), .req1_a(4'h0), .req1_b(4'h0), .req1_cin(1'b0),
        .res_valid(rv4), .res_ready(rr4), .res_sum(s4),
        .res_cout(co4), .res_id(id4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Advance until res_valid rises (bounded); readies must stay low while busy
    task automatic wait_result(output int cnt);
        cnt = 0;
        while (!res_valid && cnt < 20) begin
            tick();
            cnt++;
            check("busy_readies", {30'd0, rdy0, rdy1}, 32'd0);
        end
    endtask

    initial begin
        rst = 1'b1; rr = 1'b0;
        r0v = 1'b0; r1v = 1'b0; r0c = 1'b0; r1c = 1'b0;
        r0a = '0; r0b = '0; r1a = '0; r1b = '0;
        v4 = 1'b0; c4 = 1'b0; rr4 = 1'b1; a4 = '0; b4 = '0;

        // Reset state; ready gated by reset even with valid high
        tick(); tick();
        r0v = 1'b1;
        #1;
        check("rst_ready0", rdy0, 0);
        check("rst_valid", res_valid, 0);
        check("rst_sum", res_sum, 0);
        check("rst_cout", res_cout, 0);
        check("rst_id", res_id, 0);
        r0v = 1'b0; rst = 1'b0;
        tick();

        // req0 alone: 0x1234 + 0x4321
        r0v = 1'b1; r0a = 16'h1234; r0b = 16'h4321; r0c = 1'b0; rr = 1'b1;
        #1;
        check("t1_ready0", rdy0, 1);
        check("t1_ready1", rdy1, 0);
        tick();
        r0v = 1'b0;
        wait_result(n);
        check("t1_latency", n, 4);
        check("t1_sum", res_sum, 32'h5555);
        check("t1_cout", res_cout, 0);
        check("t1_id", res_id, 0);
        tick();
        check("t1_valid_1cyc", res_valid, 0);

        // req1 alone: carry ripples through every slice
        r1v = 1'b1; r1a = 16'hFFFF; r1b = 16'h0000; r1c = 1'b1;
        #1;
        check("t2_ready1", rdy1, 1);
        check("t2_ready0", rdy0, 0);
        tick();
        r1v = 1'b0;
        wait_result(n);
        check("t2_latency", n, 4);
        check("t2_sum", res_sum, 32'h0000);
        check("t2_cout", res_cout, 1);
        check("t2_id", res_id, 1);
        tick();

        // Both valid continuously: grants alternate 0,1,0,1
        r0v = 1'b1; r0a = 16'h00FF; r0b = 16'h0001; r0c = 1'b0;
        r1v = 1'b1; r1a = 16'h8000; r1b = 16'h8000; r1c = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("t3_ready0", rdy0, (k % 2 == 0) ? 1 : 0);
            check("t3_ready1", rdy1, (k % 2 == 1) ? 1 : 0);
            tick();
            wait_result(n);
            check("t3_latency", n, 4);
            check("t3_id", res_id, k % 2);
            check("t3_sum", res_sum, (k % 2 == 0) ? 32'h0100 : 32'h0000);
            check("t3_cout", res_cout, (k % 2 == 0) ? 0 : 1);
            if (k == 3) begin r0v = 1'b0; r1v = 1'b0; end
            tick();
        end

        // Backpressure in DONE with req0 still valid
        r0v = 1'b1; r0a = 16'h0011; r0b = 16'h0022; r0c = 1'b0; rr = 1'b0;
        #1;
        check("t4_ready0", rdy0, 1);
        tick();
        wait_result(n);
        check("t4_latency", n, 4);
        for (int k = 0; k < 10; k++) begin
            tick();
            check("t4_hold_valid", res_valid, 1);
            check("t4_hold_sum", res_sum, 32'h0033);
            check("t4_hold_id", res_id, 0);
            check("t4_hold_ready0", rdy0, 0);
        end
        rr = 1'b1;
        tick();
        check("t4_released", res_valid, 0);
        check("t4_ready_again", rdy0, 1);
        tick();
        check("t4_accepted", rdy0, 0);
        r0v = 1'b0;
        wait_result(n);
        check("t4_latency2", n, 4);
        check("t4_sum2", res_sum, 32'h0033);
        tick();

        // Reset after two RUN slices discards the operation
        r0v = 1'b1; r0a = 16'h0FFF; r0b = 16'h0001; r0c = 1'b0;
        tick();
        r0v = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_valid", res_valid, 0);
        check("t5_sum", res_sum, 0);
        check("t5_cout", res_cout, 0);
        check("t5_id", res_id, 0);
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (res_valid) seen = 1'b1;
        end
        check("t5_no_result", seen, 0);
        r0v = 1'b1; r1v = 1'b1; r1a = 16'h0001; r1b = 16'h0001; r1c = 1'b0;
        #1;
        check("t5_ready0", rdy0, 1);
        check("t5_ready1", rdy1, 0);
        tick();
        r0v = 1'b0; r1v = 1'b0;
        wait_result(n);
        check("t5_latency", n, 4);
        check("t5_sum2", res_sum, 32'h1000);
        check("t5_cout2", res_cout, 0);
        check("t5_id2", res_id, 0);
        tick();

        // WIDTH=4 build: 9 + 8 + 1 = 0x12
        v4 = 1'b1; a4 = 4'h9; b4 = 4'h8; c4 = 1'b1;
        #1;
        check("w4_ready", rdy4, 1);
        tick();
        v4 = 1'b0;
        check("w4_not_yet", rv4, 0);
        tick();
        check("w4_valid", rv4, 1);
        check("w4_sum", s4, 32'h2);
        check("w4_cout", co4, 1);
        check("w4_id", id4, 0);
        tick();
        check("w4_valid_drop", rv4, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
